load_store_unit: RTL and testbench

//  Initiator side of the data-memory interface: MEM-stage engine that turns CPU load/store requests
//  (byte/half/word, signed/unsigned) into word-indexed memory reads and writes. Sub-word stores run
//  as read-modify-write. Sits between the EX/MEM pipeline register and the data memory.

---
 rtl/mips_mem_pkg.sv | 19 +
 rtl/load_store_unit_align.sv | 34 +++
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package mips_mem_pkg;
  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, ERR} lsu_state_t;

  // Only the byte offset of the address is kept; the word index lives in mem_addr.
  typedef struct packed {
    logic              is_load;
    logic [1:0]        size;
    logic              sgn;
    logic [1:0]        addr_lo;
    logic [DATA_W-1:0] wdata;
  } lsu_req_t;
endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge (little-endian).
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_addr_lo,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load,
  output logic [DATA_W-1:0] o_merged
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = i_word[{i_addr_lo, 3'b000} +: 8];
    w_half   = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    o_load   = i_word;
    o_merged = i_word;
    case (i_size)
      SZ_BYTE: begin
        o_load = {{24{i_signed & w_byte[7]}}, w_byte};
        o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load = {{16{i_signed & w_half[15]}}, w_half};
        if (i_addr_lo[1]) o_merged[31:16] = i_wdata[15:0];
        else              o_merged[15:0]  = i_wdata[15:0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store engine: word-indexed memory access, sub-word stores as read-modify-write.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_load,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [IDX_W-1:0]  mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  lsu_state_t        r_state;
  lsu_req_t          r_req;
  logic              r_resp_valid, r_resp_err;
  logic [31:0]       r_resp_rdata;
  logic [IDX_W-1:0]  r_mem_addr;
  logic              r_mem_rd, r_mem_wr;
  logic [31:0]       r_mem_wdata;

  logic              w_err;
  logic [31:0]       w_load, w_merged;

  always_comb begin
    w_err = (req_size == 2'b11)
         || (req_size == SZ_HALF && req_addr[0])
         || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
         || (req_addr >= 32'(4 * DEPTH_WORDS));
  end

  lsu_lane_align u_align (
    .i_word    (mem_rdata),
    .i_addr_lo (r_req.addr_lo),
    .i_size    (r_req.size),
    .i_signed  (r_req.sgn),
    .i_wdata   (r_req.wdata),
    .o_load    (w_load),
    .o_merged  (w_merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_addr   <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      case (r_state)
        IDLE: if (req_valid) begin
          r_req <= '{is_load: req_is_load, size: req_size, sgn: req_signed,
                     addr_lo: req_addr[1:0], wdata: req_wdata};
          if (w_err) begin
            r_state <= ERR;
          end else if (req_is_load || req_size == SZ_WORD) begin
            r_state     <= ACCESS;
            r_mem_addr  <= req_addr[IDX_W+1:2];
            r_mem_rd    <= req_is_load;
            r_mem_wr    <= ~req_is_load;
            r_mem_wdata <= req_is_load ? '0 : req_wdata;
          end else begin
            r_state    <= RMW_RD;
            r_mem_addr <= req_addr[IDX_W+1:2];
            r_mem_rd   <= 1'b1;
          end
        end
        ACCESS: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= r_req.is_load ? w_load : '0;
          r_mem_addr   <= '0;
          r_mem_rd     <= 1'b0;
          r_mem_wr     <= 1'b0;
          r_mem_wdata  <= '0;
        end
        // Old word is merged here so the write cycle drives a registered wdata.
        RMW_RD: begin
          r_state     <= RMW_WR;
          r_mem_rd    <= 1'b0;
          r_mem_wr    <= 1'b1;
          r_mem_wdata <= w_merged;
        end
        RMW_WR: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b1;
          r_mem_addr   <= '0;
          r_mem_wr     <= 1'b0;
          r_mem_wdata  <= '0;
        end
        ERR: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gating with reset drops a write that is pending in the reset cycle.
  assign mem_rd     = r_mem_rd & ~reset;
  assign mem_wr     = r_mem_wr & ~reset;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign req_ready  = (r_state == IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: 64-word memory, byte-level reference model, directed + random requests.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_load, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [5:0]  mem_addr;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] tb_mem  [64];
  logic [31:0] ref_mem [64];

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH_WORDS(64), .IDX_W(6)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) if (mem_wr) tb_mem[mem_addr] <= mem_wdata;
  assign mem_rdata = tb_mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_err(input bit [1:0] sz, input bit [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 0) || (a >= 32'd256);
  endfunction

  function automatic logic [31:0] m_load(input bit [1:0] sz, input bit sg, input bit [31:0] a);
    logic [31:0] w, v;
    w = ref_mem[a[7:2]];
    if (sz == 2'd0) begin
      v = (w >> (8 * a[1:0])) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * a[1])) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF0000;
    end else v = w;
    return v;
  endfunction

  function automatic logic [31:0] m_store(input bit [1:0] sz, input bit [31:0] a, input bit [31:0] wd);
    logic [31:0] w, mask;
    int sh;
    w = ref_mem[a[7:2]];
    if (sz == 2'd0)      begin sh = 8 * a[1:0];  mask = 32'hFF << sh; end
    else if (sz == 2'd1) begin sh = 16 * a[1];   mask = 32'hFFFF << sh; end
    else                 begin sh = 0;           mask = 32'hFFFFFFFF; end
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic xfer(input bit ld, input bit [1:0] sz, input bit sg, input bit [31:0] a,
                      input bit [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat, output int nrd, output int nwr, output int ovl,
                      output logic [31:0] wdat, output logic [5:0] waddr, output bit ok);
    int n;
    ok = 1'b1; lat = 0; nrd = 0; nwr = 0; ovl = 0; rd = 'x; er = 'x; wdat = 'x; waddr = 'x;
    @(negedge clk);
    req_valid = 1'b1; req_is_load = ld; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) ok = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      lat++;
      if (mem_rd) nrd++;
      if (mem_wr) begin nwr++; wdat = mem_wdata; waddr = mem_addr; end
      if (mem_rd && mem_wr) ovl++;
      if (resp_valid) begin rd = resp_rdata; er = resp_err; break; end
    end
    if (resp_valid !== 1'b1) ok = 1'b0;
  endtask

  task automatic run(input string tag, input bit ld, input bit [1:0] sz, input bit sg,
                     input bit [31:0] a, input bit [31:0] wd, output logic [31:0] rd_o);
    logic [31:0] rd, wdat, nw, erd;
    logic er;
    logic [5:0] waddr;
    int lat, nrd, nwr, ovl;
    bit ok, e_err;
    xfer(ld, sz, sg, a, wd, rd, er, lat, nrd, nwr, ovl, wdat, waddr, ok);
    rd_o  = rd;
    e_err = m_err(sz, a);
    erd   = (!e_err && ld) ? m_load(sz, sg, a) : 32'h0;
    chk({tag, ".done"}, 32'(ok), 32'd1);
    chk({tag, ".err"}, 32'(er), 32'(e_err));
    chk({tag, ".rdata"}, rd, erd);
    chk({tag, ".lat"}, lat, (!e_err && !ld && sz != 2'd2) ? 3 : 2);
    chk({tag, ".nrd"}, nrd, (!e_err && (ld || sz != 2'd2)) ? 1 : 0);
    chk({tag, ".nwr"}, nwr, (!e_err && !ld) ? 1 : 0);
    chk({tag, ".ovl"}, ovl, 0);
    if (!e_err && !ld) begin
      nw = m_store(sz, a, wd);
      chk({tag, ".wdata"}, wdat, nw);
      chk({tag, ".waddr"}, 32'(waddr), 32'(a[7:2]));
      ref_mem[a[7:2]] = nw;
      chk({tag, ".memword"}, tb_mem[a[7:2]], nw);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r, pre;
    logic [31:0] t6_addr [4];
    logic [31:0] t6_exp  [4];
    logic [31:0] got [$];
    int acc_c [4];
    int nacc, ovl, extra;
    bit rdy;

    reset = 1'b1; req_valid = 1'b0; req_is_load = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_err", 32'(resp_err), 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'd0);
    chk("rst.mem_rd", 32'(mem_rd), 32'd0);
    chk("rst.mem_wr", 32'(mem_wr), 32'd0);
    chk("rst.mem_addr", 32'(mem_addr), 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);

    for (int i = 0; i < 64; i++) run($sformatf("pre%0d", i), 1'b0, 2'd2, 1'b0, 32'(i * 4), $urandom, r);

    run("t1.sw", 1'b0, 2'd2, 1'b0, 32'h10, 32'h12345678, r);
    run("t1.lw", 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, r);
    chk("t1.lw.lit", r, 32'h12345678);

    run("t2.sw", 1'b0, 2'd2, 1'b0, 32'h08, 32'h11223344, r);
    run("t2.sb", 1'b0, 2'd0, 1'b0, 32'h09, 32'h000000AA, r);
    chk("t2.sb.lit", tb_mem[2], 32'h1122AA44);

    run("t3.sw", 1'b0, 2'd2, 1'b0, 32'h00, 32'h0000F080, r);
    run("t3.lb", 1'b1, 2'd0, 1'b1, 32'h00, 32'h0, r);  chk("t3.lb.lit", r, 32'hFFFFFF80);
    run("t3.lbu", 1'b1, 2'd0, 1'b0, 32'h00, 32'h0, r); chk("t3.lbu.lit", r, 32'h00000080);
    run("t3.lh", 1'b1, 2'd1, 1'b1, 32'h00, 32'h0, r);  chk("t3.lh.lit", r, 32'hFFFFF080);
    run("t3.lhu", 1'b1, 2'd1, 1'b0, 32'h02, 32'h0, r); chk("t3.lhu.lit", r, 32'h00000000);

    run("t4.lh3", 1'b1, 2'd1, 1'b1, 32'h03, 32'h0, r);
    run("t4.lw6", 1'b1, 2'd2, 1'b0, 32'h06, 32'h0, r);
    run("t4.sz3", 1'b1, 2'd3, 1'b0, 32'h10, 32'h0, r);
    run("t4.oor", 1'b1, 2'd2, 1'b0, 32'h100, 32'h0, r);
    run("t4.sboor", 1'b0, 2'd0, 1'b0, 32'h1FF, 32'h55, r);

    for (int i = 0; i < 80; i++) begin
      bit ld, sg;
      bit [1:0] sz;
      bit [31:0] a;
      int k;
      ld = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      k  = $urandom_range(0, 9);
      sz = (k < 3) ? 2'd0 : (k < 6) ? 2'd1 : (k < 9) ? 2'd2 : 2'd3;
      a  = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 15) == 0) a = $urandom_range(256, 100000);
      run($sformatf("rnd%0d", i), ld, sz, sg, a, $urandom, r);
    end

    // Reset lands in the write cycle of a half-word RMW.
    pre = ref_mem[1];
    @(negedge clk);
    chk("t5.ready0", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_is_load = 1'b0; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 32'h04; req_wdata = 32'h0000BEEF;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    chk("t5.rmw_rd", 32'(mem_rd), 32'd1);
    @(negedge clk);
    chk("t5.rmw_wr", 32'(mem_wr), 32'd1);
    reset = 1'b1; #1;
    chk("t5.wr_dropped", 32'(mem_wr), 32'd0);
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    chk("t5.ready", 32'(req_ready), 32'd1);
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid) extra++;
      @(negedge clk);
    end
    chk("t5.no_resp", extra, 0);
    chk("t5.mem_kept", tb_mem[1], pre);

    // Back-to-back loads with req_valid held high.
    for (int k = 0; k < 4; k++) begin
      t6_addr[k] = 32'(4 * (10 + 3 * k) + k);
      t6_exp[k]  = m_load(2'd0, 1'b1, t6_addr[k]);
    end
    nacc = 0; ovl = 0;
    req_valid = 1'b1; req_is_load = 1'b1; req_size = 2'd0; req_signed = 1'b1;
    req_addr = t6_addr[0]; req_wdata = '0;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      if (resp_valid) got.push_back(resp_rdata);
      if (mem_rd && mem_wr) ovl++;
      if (nacc > 0 && c == acc_c[nacc-1] + 1) chk($sformatf("t6.busy%0d", nacc), 32'(req_ready), 32'd0);
      rdy = req_ready && req_valid;
      @(posedge clk);
      if (rdy) begin
        acc_c[nacc] = c;
        nacc++;
        #1;
        if (nacc < 4) req_addr = t6_addr[nacc];
        else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid) got.push_back(resp_rdata);
      @(negedge clk);
    end
    chk("t6.nacc", nacc, 4);
    chk("t6.nresp", got.size(), 4);
    chk("t6.ovl", ovl, 0);
    for (int k = 1; k < 4 && k < nacc; k++) chk($sformatf("t6.gap%0d", k), acc_c[k] - acc_c[k-1], 2);
    for (int k = 0; k < 4 && k < got.size(); k++) chk($sformatf("t6.rdata%0d", k), got[k], t6_exp[k]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
